// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] sa, sb, sd_full;
    logic [WIDTH-2:0] sd;
    logic [CW-1:0]    cnt;
    logic             br, x, y, d, br_next, last, load;
    always_comb begin
        x          = sa[0];
        y          = sb[0];
        d          = x ^ y ^ br;
        br_next    = (~x & y) | (~(x ^ y) & br);
        sd_full    = {d, sd};
        last       = cnt == CW'(WIDTH - 1);
        load       = start && state != RUN;
        state_next = load ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
        busy       = state == RUN;
        done       = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end
    // sd keeps only the WIDTH-1 bits gathered so far; the last bit joins it straight into diff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            sd   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= br_next;
            sd  <= sd_full[WIDTH-1:1];
            cnt <= cnt + CW'(1);
            if (last) begin
                diff <= sd_full;
                bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                ovf  <= br ^ br_next;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed vector table plus randomized model comparison for serial_sub at WIDTH 8, 2 and 16.
module tb_serial_sub;
    logic        clk = 1'b0, rst_n = 1'b0, st = 1'b0, bin_in = 1'b0;
    logic [63:0] a_in = '0, b_in = '0;
    int          sel = 8, checks = 0, errors = 0, cyc = 0;
    logic        busy8, done8, bout8, busy2, done2, bout2, busy16, done16, bout16;
    logic [7:0]  diff8;
    logic [1:0]  diff2;
    logic [15:0] diff16;
    logic        cur_busy, cur_done, cur_bout;
    logic [63:0] cur_diff;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf8, ovf2, ovf16, cur_ovf;
    assign cur_ovf = sel == 2 ? ovf2 : sel == 16 ? ovf16 : ovf8;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st && sel == 8), .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );
    serial_sub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st && sel == 2), .a(a_in[1:0]), .b(b_in[1:0]), .bin(bin_in),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf2)
`endif
    );
    serial_sub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st && sel == 16), .a(a_in[15:0]), .b(b_in[15:0]), .bin(bin_in),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf16)
`endif
    );

    assign cur_busy = sel == 2 ? busy2 : sel == 16 ? busy16 : busy8;
    assign cur_done = sel == 2 ? done2 : sel == 16 ? done16 : done8;
    assign cur_bout = sel == 2 ? bout2 : sel == 16 ? bout16 : bout8;
    assign cur_diff = sel == 2 ? 64'(diff2) : sel == 16 ? 64'(diff16) : 64'(diff8);

    typedef struct {
        logic [7:0] a, b;
        logic       bin;
        logic [7:0] d;
        logic       bo, ov;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and sign-extended operands.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b, input logic bn,
                                  output logic [63:0] d, output logic bo, output logic ov);
        longint m  = (longint'(1) << w) - 1;
        longint ua = longint'(a), ub = longint'(b), sa, sb, r;
        d  = 64'((ua - ub - longint'(bn)) & m);
        bo = ua < ub + longint'(bn);
        sa = a[w-1] ? ua - (m + 1) : ua;
        sb = b[w-1] ? ub - (m + 1) : ub;
        r  = sa - sb - longint'(bn);
        ov = r < -((m + 1) / 2) || r > (m + 1) / 2 - 1;
    endfunction

    task automatic do_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic bn,
                         output logic [63:0] d, output logic bo, output logic ov, output int lat);
        int n = 0;
        @(negedge clk);
        sel = w; a_in = a; b_in = b; bin_in = bn; st = 1'b1;
        @(negedge clk);
        st = 1'b0; a_in = '1; b_in = '0; bin_in = 1'b1;
        lat = 0;
        while (!cur_done && n < 200) begin
            lat += int'(cur_busy);
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 64'(n < 200), 64'(1));
        d  = cur_diff;
        bo = cur_bout;
`ifdef SERIAL_SUB_OVF_EN
        ov = cur_ovf;
`else
        ov = 1'b0;
`endif
    endtask

    initial begin
        logic [63:0] d, ed, m;
        logic        bo, ov, ebo, eov, seen;
        int          lat, n, t[4];
        vecs[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[1] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h7F, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy8), 0);
        chk("rst_done", 64'(done8), 0);
        chk("rst_diff", 64'(diff8), 0);
        chk("rst_bout", 64'(bout8), 0);
        rst_n = 1'b1;

        do_op(8, 64'h35, 64'h12, 1'b0, d, bo, ov, lat);
        chk("basic_lat", 64'(lat), 8);
        chk("basic_diff", d, 64'h23);
        chk("basic_bout", 64'(bo), 0);
        @(negedge clk);
        chk("done_pulse_width", 64'(done8), 0);

        for (int i = 0; i < 7; i++) begin
            do_op(8, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].bin, d, bo, ov, lat);
            chk($sformatf("vec%0d_diff", i), d, 64'(vecs[i].d));
            chk($sformatf("vec%0d_bout", i), 64'(bo), 64'(vecs[i].bo));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 8);
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].ov));
`endif
        end

        // start held high: results must arrive every WIDTH+1 cycles
        @(negedge clk);
        sel = 8; a_in = 64'h05; b_in = 64'h03; bin_in = 1'b0; st = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!done8 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_timeout", 64'(n < 50), 1);
            t[k] = cyc;
            chk("b2b_diff", 64'(diff8), 64'h02);
            if (k > 0) chk("b2b_interval", 64'(t[k] - t[k-1]), 9);
            @(negedge clk);
        end
        st = 1'b0;

        // reset asserted with cnt=4
        @(negedge clk);
        sel = 8; a_in = 64'h44; b_in = 64'h11; bin_in = 1'b0; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", 64'(busy8), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy8), 0);
        chk("abort_done", 64'(done8), 0);
        chk("abort_diff", 64'(diff8), 0);
        chk("abort_bout", 64'(bout8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= done8;
        end
        chk("abort_no_done", 64'(seen), 0);
        do_op(8, 64'h44, 64'h11, 1'b0, d, bo, ov, lat);
        chk("after_abort_diff", d, 64'h33);
        chk("after_abort_bout", 64'(bo), 0);

        foreach (t[j]) t[j] = 0;
        for (int wi = 0; wi < 2; wi++) begin
            automatic int w = wi == 0 ? 2 : 16;
            m = (64'h1 << w) - 1;
            for (int i = 0; i < 500; i++) begin
                logic [63:0] ra, rb;
                logic        rbn;
                ra  = $urandom_range(0, 4) == 0 ? 64'h0 : $urandom_range(0, 4) == 0 ? m : {$urandom, $urandom} & m;
                rb  = $urandom_range(0, 4) == 0 ? 64'h0 : $urandom_range(0, 4) == 0 ? m : {$urandom, $urandom} & m;
                rbn = 1'($urandom_range(0, 1));
                model(w, ra, rb, rbn, ed, ebo, eov);
                do_op(w, ra, rb, rbn, d, bo, ov, lat);
                chk($sformatf("rnd_w%0d_diff a=%0h b=%0h bin=%0b", w, ra, rb, rbn), d, ed);
                chk($sformatf("rnd_w%0d_bout a=%0h b=%0h bin=%0b", w, ra, rb, rbn), 64'(bo), 64'(ebo));
                chk($sformatf("rnd_w%0d_lat", w), 64'(lat), 64'(w));
`ifdef SERIAL_SUB_OVF_EN
                chk($sformatf("rnd_w%0d_ovf a=%0h b=%0h bin=%0b", w, ra, rb, rbn), 64'(ov), 64'(eov));
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
